// File: rtl/cmd_rx_decoder.sv
// cmd_rx_decoder: turns the host UART byte stream into control-unit commands.
// Command bytes become a one-hot command vector with a command_ready pulse.
// A WRITE command is followed by NUM_ELEMENTOS little-endian elements that
// are assembled and streamed to vector memory A or B. write_done marks the end
// of a payload, whether it completed or was aborted by the idle timeout.
module cmd_rx_decoder #(
  parameter int NUM_ELEMENTOS  = 1024,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [7:0]                       rx_data,
  input  logic                             rx_ready,
  output logic [7:0]                       command,
  output logic                             command_ready,
  output logic                             write_done,
  output logic                             mem_we,
  output logic                             mem_sel,
  output logic [$clog2(NUM_ELEMENTOS)-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  output logic                             cmd_error
);

  localparam int BYTES_PER_ELEM = DATA_WIDTH / 8;
  localparam int BCNT_W  = (BYTES_PER_ELEM > 1) ? $clog2(BYTES_PER_ELEM) : 1;
  localparam int ADDR_W  = $clog2(NUM_ELEMENTOS);
  localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [BCNT_W-1:0]  LAST_BYTE  = BCNT_W'(BYTES_PER_ELEM - 1);
  localparam logic [ADDR_W-1:0]  LAST_ELEM  = ADDR_W'(NUM_ELEMENTOS - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]         OP_WRITE   = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RX_DATA = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // A command byte is legal when its upper nibble is clear and the opcode is non-zero.
  function automatic logic cmd_legal(input logic [7:0] b);
    return (b[7:4] == 4'h0) && (b[2:0] != 3'd0);
  endfunction

  // Map a legal command byte to the one-hot operation vector plus memory select.
  // Bit 7 is inverted relative to byte bit 3: the control unit wants 1 = memory A.
  function automatic logic [7:0] cmd_decode(input logic [7:0] b);
    logic [7:0] c;
    c = 8'h00;
    case (b[2:0])
      3'd1:    c[0] = 1'b1;
      3'd2:    c[1] = 1'b1;
      3'd3:    c[2] = 1'b1;
      3'd4:    c[3] = 1'b1;
      3'd5:    c[4] = 1'b1;
      3'd6:    c[5] = 1'b1;
      3'd7:    c[6] = 1'b1;
      default: c = 8'h00;
    endcase
    c[7] = ~b[3];
    return c;
  endfunction

  // Drop a payload byte into its little-endian lane of the element being assembled.
  function automatic logic [DATA_WIDTH-1:0] asm_insert(
    input logic [DATA_WIDTH-1:0] cur,
    input logic [BCNT_W-1:0]     pos,
    input logic [7:0]            b
  );
    logic [DATA_WIDTH-1:0] r;
    r = cur;
    for (int i = 0; i < BYTES_PER_ELEM; i++) begin
      r[8*i +: 8] = (pos == BCNT_W'(i)) ? b : cur[8*i +: 8];
    end
    return r;
  endfunction

  state_t                state_r, state_s;
  logic [BCNT_W-1:0]     byte_cnt_r, byte_cnt_s;
  logic [ADDR_W-1:0]     elem_cnt_r, elem_cnt_s;
  logic [TIMER_W-1:0]    timer_r, timer_s;
  logic [DATA_WIDTH-1:0] asm_r, asm_s;

  logic [7:0]            command_r, command_s;
  logic                  command_ready_r, command_ready_s;
  logic                  write_done_r, write_done_s;
  logic                  mem_we_r, mem_we_s;
  logic                  mem_sel_r, mem_sel_s;
  logic [ADDR_W-1:0]     mem_addr_r, mem_addr_s;
  logic [DATA_WIDTH-1:0] mem_wdata_r, mem_wdata_s;
  logic                  cmd_error_r, cmd_error_s;

  // Next-state, counters and next output values; pulses default low, data holds.
  always_comb begin
    state_s         = state_r;
    byte_cnt_s      = byte_cnt_r;
    elem_cnt_s      = elem_cnt_r;
    timer_s         = timer_r;
    asm_s           = asm_r;
    command_s       = command_r;
    command_ready_s = 1'b0;
    write_done_s    = 1'b0;
    mem_we_s        = 1'b0;
    mem_sel_s       = mem_sel_r;
    mem_addr_s      = mem_addr_r;
    mem_wdata_s     = mem_wdata_r;
    cmd_error_s     = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (rx_ready) begin
          if (cmd_legal(rx_data)) begin
            command_s       = cmd_decode(rx_data);
            command_ready_s = 1'b1;
            if (rx_data[2:0] == OP_WRITE) begin
              state_s    = ST_RX_DATA;
              byte_cnt_s = {BCNT_W{1'b0}};
              elem_cnt_s = {ADDR_W{1'b0}};
              timer_s    = {TIMER_W{1'b0}};
              asm_s      = {DATA_WIDTH{1'b0}};
              mem_sel_s  = rx_data[3];
            end else begin
              state_s = ST_IDLE;
            end
          end else begin
            // Illegal byte: flag it, leave the held command untouched.
            cmd_error_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_RX_DATA: begin
        if (rx_ready) begin
          // Every byte here is payload, even if it looks like a command.
          timer_s = {TIMER_W{1'b0}};
          asm_s   = asm_insert(asm_r, byte_cnt_r, rx_data);
          if (byte_cnt_r == LAST_BYTE) begin
            mem_we_s    = 1'b1;
            mem_addr_s  = elem_cnt_r;
            mem_wdata_s = asm_s;
            byte_cnt_s  = {BCNT_W{1'b0}};
            if (elem_cnt_r == LAST_ELEM) begin
              // Counter saturates at the last element; DONE clears it.
              state_s    = ST_DONE;
              elem_cnt_s = elem_cnt_r;
            end else begin
              elem_cnt_s = elem_cnt_r + ADDR_W'(1);
            end
          end else begin
            byte_cnt_s = byte_cnt_r + BCNT_W'(1);
          end
        end else if (timer_r == TIMER_LAST) begin
          // Host went quiet mid-payload: abort so the control unit can leave WRITE.
          cmd_error_s  = 1'b1;
          write_done_s = 1'b1;
          state_s      = ST_IDLE;
          timer_s      = {TIMER_W{1'b0}};
          byte_cnt_s   = {BCNT_W{1'b0}};
          elem_cnt_s   = {ADDR_W{1'b0}};
        end else begin
          timer_s = timer_r + TIMER_W'(1);
        end
      end

      ST_DONE: begin
        // Any byte arriving in this single cycle is dropped.
        write_done_s = 1'b1;
        state_s      = ST_IDLE;
        elem_cnt_s   = {ADDR_W{1'b0}};
      end

      default: begin
        state_s    = ST_IDLE;
        byte_cnt_s = {BCNT_W{1'b0}};
        elem_cnt_s = {ADDR_W{1'b0}};
        timer_s    = {TIMER_W{1'b0}};
      end
    endcase
  end

  // State, counters and registered outputs; reset clears everything and drops any partial element.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      byte_cnt_r      <= {BCNT_W{1'b0}};
      elem_cnt_r      <= {ADDR_W{1'b0}};
      timer_r         <= {TIMER_W{1'b0}};
      asm_r           <= {DATA_WIDTH{1'b0}};
      command_r       <= 8'h00;
      command_ready_r <= 1'b0;
      write_done_r    <= 1'b0;
      mem_we_r        <= 1'b0;
      mem_sel_r       <= 1'b0;
      mem_addr_r      <= {ADDR_W{1'b0}};
      mem_wdata_r     <= {DATA_WIDTH{1'b0}};
      cmd_error_r     <= 1'b0;
    end else begin
      state_r         <= state_s;
      byte_cnt_r      <= byte_cnt_s;
      elem_cnt_r      <= elem_cnt_s;
      timer_r         <= timer_s;
      asm_r           <= asm_s;
      command_r       <= command_s;
      command_ready_r <= command_ready_s;
      write_done_r    <= write_done_s;
      mem_we_r        <= mem_we_s;
      mem_sel_r       <= mem_sel_s;
      mem_addr_r      <= mem_addr_s;
      mem_wdata_r     <= mem_wdata_s;
      cmd_error_r     <= cmd_error_s;
    end
  end

  assign command       = command_r;
  assign command_ready = command_ready_r;
  assign write_done    = write_done_r;
  assign mem_we        = mem_we_r;
  assign mem_sel       = mem_sel_r;
  assign mem_addr      = mem_addr_r;
  assign mem_wdata     = mem_wdata_r;
  assign cmd_error     = cmd_error_r;

endmodule

// File: tb/tb_cmd_rx_decoder.sv
// Testbench for cmd_rx_decoder: directed scenarios followed by random byte
// traffic, checked every cycle against a byte-queue model of the decoder,
// plus hand-computed pins on command and cumulative pulse counts.
module tb_cmd_rx_decoder;

  localparam int NUM_ELEMENTOS  = 4;
  localparam int DATA_WIDTH     = 16;
  localparam int TIMEOUT_CYCLES = 50;
  localparam int BPE            = DATA_WIDTH / 8;
  localparam int AW             = $clog2(NUM_ELEMENTOS);

  logic                  clk = 1'b0;
  logic                  reset;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic [7:0]            command;
  logic                  command_ready;
  logic                  write_done;
  logic                  mem_we;
  logic                  mem_sel;
  logic [AW-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  cmd_error;

  always #5 clk = ~clk;

  cmd_rx_decoder #(
    .NUM_ELEMENTOS (NUM_ELEMENTOS),
    .DATA_WIDTH    (DATA_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .command      (command),
    .command_ready(command_ready),
    .write_done   (write_done),
    .mem_we       (mem_we),
    .mem_sel      (mem_sel),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cmd_error    (cmd_error)
  );

  // ---------------- behavioural model (written only by the driver) ----------
  logic [7:0]            exp_command    = 8'h00;
  logic                  exp_cmd_ready  = 1'b0;
  logic                  exp_write_done = 1'b0;
  logic                  exp_mem_we     = 1'b0;
  logic                  exp_mem_sel    = 1'b0;
  int                    exp_addr       = 0;
  logic [DATA_WIDTH-1:0] exp_wdata      = '0;
  logic                  exp_cmd_error  = 1'b0;

  bit         m_payload   = 1'b0;  // inside a WRITE payload
  bit         m_done_wait = 1'b0;  // one cycle after the last element write
  logic [7:0] m_bytes[$];          // bytes of the element being collected
  int         m_elems     = 0;     // elements already written this payload
  int         m_idle      = 0;     // consecutive silent cycles in the payload

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    int op;
    exp_cmd_ready  = 1'b0;
    exp_write_done = 1'b0;
    exp_mem_we     = 1'b0;
    exp_cmd_error  = 1'b0;
    if (reset) begin
      exp_command = 8'h00;
      exp_mem_sel = 1'b0;
      m_payload   = 1'b0;
      m_done_wait = 1'b0;
      m_bytes.delete();
      m_elems     = 0;
      m_idle      = 0;
    end else if (m_done_wait) begin
      exp_write_done = 1'b1;
      m_done_wait    = 1'b0;
    end else if (m_payload) begin
      if (rx_ready) begin
        m_idle = 0;
        m_bytes.push_back(rx_data);
        if (m_bytes.size() == BPE) begin
          exp_mem_we = 1'b1;
          exp_addr   = m_elems;
          exp_wdata  = '0;
          for (int i = 0; i < BPE; i++)
            exp_wdata = exp_wdata | (DATA_WIDTH'(m_bytes[i]) << (8 * i));
          m_bytes.delete();
          m_elems++;
          if (m_elems == NUM_ELEMENTOS) begin
            m_payload   = 1'b0;
            m_done_wait = 1'b1;
          end
        end
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT_CYCLES) begin
          exp_cmd_error  = 1'b1;
          exp_write_done = 1'b1;
          m_payload      = 1'b0;
          m_bytes.delete();
        end
      end
    end else if (rx_ready) begin
      op = int'(rx_data[2:0]);
      if (rx_data[7:4] != 4'h0 || op == 0) begin
        exp_cmd_error = 1'b1;
      end else begin
        exp_cmd_ready = 1'b1;
        exp_command   = (8'h01 << (op - 1)) | (rx_data[3] ? 8'h00 : 8'h80);
        if (op == 1) begin
          m_payload   = 1'b1;
          m_elems     = 0;
          m_idle      = 0;
          m_bytes.delete();
          exp_mem_sel = rx_data[3];
        end
      end
    end
  endtask

  // ---------------- literal pins (written only by the driver) ---------------
  int                    pin_cyc   = -1;
  logic [7:0]            pin_cmd   = 8'h00;
  int                    pin_we    = 0;
  int                    pin_wd    = 0;
  int                    pin_err   = 0;
  logic [DATA_WIDTH-1:0] pin_wdata = '0;

  // ---------------- compare process (sole owner of the counters) ------------
  int                    errs       = 0;
  int                    checks     = 0;
  int                    cyc        = 0;
  int                    cnt_we     = 0;
  int                    cnt_wd     = 0;
  int                    cnt_err    = 0;
  logic [DATA_WIDTH-1:0] last_wdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("command",       32'(command),       32'(exp_command));
      chk("command_ready", 32'(command_ready), 32'(exp_cmd_ready));
      chk("write_done",    32'(write_done),    32'(exp_write_done));
      chk("mem_we",        32'(mem_we),        32'(exp_mem_we));
      chk("mem_sel",       32'(mem_sel),       32'(exp_mem_sel));
      chk("cmd_error",     32'(cmd_error),     32'(exp_cmd_error));
      if (exp_mem_we) begin
        chk("mem_addr",  32'(mem_addr),  32'(exp_addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
      end
      if (mem_we === 1'b1) begin
        cnt_we++;
        last_wdata = mem_wdata;
      end
      if (write_done === 1'b1) cnt_wd++;
      if (cmd_error === 1'b1) cnt_err++;
      if (cyc == pin_cyc) begin
        chk("pin_command",       32'(command),     32'(pin_cmd));
        chk("pin_model_command", 32'(exp_command), 32'(pin_cmd));
        chk("pin_mem_we_count",  32'(cnt_we),      32'(pin_we));
        chk("pin_done_count",    32'(cnt_wd),      32'(pin_wd));
        chk("pin_error_count",   32'(cnt_err),     32'(pin_err));
        chk("pin_last_wdata",    32'(last_wdata),  32'(pin_wdata));
      end
      cyc++;
    end
  end

  // ---------------- driver ---------------------------------------------------
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic set_pin(input logic [7:0] cmd, input int we, input int wd,
                         input int err, input logic [DATA_WIDTH-1:0] wdata);
    pin_cmd   = cmd;
    pin_we    = we;
    pin_wd    = wd;
    pin_err   = err;
    pin_wdata = wdata;
    pin_cyc   = cyc;
    tick();
  endtask

  function automatic logic [7:0] rand_byte();
    if ($urandom_range(0, 9) < 2) return 8'($urandom);
    return {4'h0, 1'($urandom), 3'($urandom_range(0, 7))};
  endfunction

  initial begin
    int r;
    int g;
    reset    = 1'b1;
    rx_ready = 1'b0;
    rx_data  = 8'h00;
    idle(3);
    reset = 1'b0;
    idle(2);
    set_pin(8'h00, 0, 0, 0, 16'h0000);

    // SUM on memory A
    send(8'h03);
    idle(2);
    set_pin(8'h84, 0, 0, 0, 16'h0000);

    // WRITE to memory B, four 16-bit elements, back-to-back bytes
    send(8'h09);
    send(8'h34); send(8'h12); send(8'h78); send(8'h56);
    send(8'hBC); send(8'h9A); send(8'hF0); send(8'hDE);
    idle(3);
    set_pin(8'h01, 4, 1, 0, 16'hDEF0);

    // Illegal bytes: opcode 0, then non-zero upper nibble
    send(8'h00);
    idle(1);
    send(8'h13);
    idle(2);
    set_pin(8'h01, 4, 1, 2, 16'hDEF0);

    // WRITE to A, one full element plus a partial, then silence until timeout
    send(8'h01);
    send(8'h34); send(8'h12); send(8'h55);
    idle(60);
    set_pin(8'h81, 5, 2, 3, 16'h1234);

    // MAN_DIST on memory A after the aborted transfer
    send(8'h06);
    idle(2);
    set_pin(8'hA0, 5, 2, 3, 16'h1234);

    // Reset after two of four elements: no write_done, all outputs cleared
    send(8'h01);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    idle(2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_pin(8'h00, 7, 2, 3, 16'hDDCC);
    send(8'h02);
    idle(2);
    set_pin(8'h82, 7, 2, 3, 16'hDDCC);

    // Random traffic: mixed commands, payloads, timeout-boundary gaps, resets
    repeat (400) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end else begin
        if ($urandom_range(0, 19) == 0) g = $urandom_range(45, 60);
        else g = $urandom_range(0, 3);
        idle(g);
        send(rand_byte());
      end
    end
    idle(70);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
